// File: rtl/instr_fetch_pkg.sv
// Shared types, widths and helpers for the instruction-fetch block.
package instr_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [1:0]  INSTR_ALIGN_MASK = 2'b11;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FAULT = 1'b1
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Memory words arrive big-endian; decode expects little-endian byte order.
  function automatic logic [ILEN-1:0] swap_bytes(input logic [ILEN-1:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Memory read port, redirect input and decode handshake of the fetch unit.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic [XLEN-1:0] mem_addr;
  logic [ILEN-1:0] mem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;
  logic            fault;
  logic [XLEN-1:0] fault_pc;

  modport master (
    output mem_addr,
    input  mem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output fault,
    output fault_pc
  );

  modport slave (
    input  mem_addr,
    output mem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  fault,
    input  fault_pc
  );
endinterface

// File: rtl/instr_fetch_fifo.sv
// Synchronous fetch buffer; head is read straight from storage registers.
module instr_fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [AW:0]      o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("instr_fetch_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_count = r_count;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // When full, a simultaneous pop frees the head slot the write lands in.
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, redirect/fault FSM, byte swap and buffered decode handshake.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter bit              BYTE_SWAP  = 1'b1,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  instr_fetch_if.master  bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  if ((RESET_PC[1:0] & INSTR_ALIGN_MASK) != 2'b00) begin : g_bad_reset_pc
    $error("instr_fetch: RESET_PC must be 4-byte aligned");
  end

  if_state_e       r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_fault;
  logic [XLEN-1:0] r_fault_pc;

  logic [CW-1:0]   w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_aligned;
  logic [ILEN-1:0] w_instr;
  fetch_entry_t    w_entry;
  fetch_entry_t    w_head;

  assign w_aligned = ((bus.redirect_pc[1:0] & INSTR_ALIGN_MASK) == 2'b00);
  assign w_instr   = BYTE_SWAP ? swap_bytes(bus.mem_rdata) : bus.mem_rdata;
  assign w_entry   = '{pc: r_pc, instr: w_instr};

  // A redirect flushes the buffer, so neither push nor pop is meaningful that cycle.
  assign w_pop  = (w_count != '0) && bus.out_ready && !bus.redirect_valid;
  assign w_push = (r_state == ST_FETCH) && !bus.redirect_valid && (!w_full || w_pop);

  instr_fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_PC;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (bus.redirect_valid) begin
            if (w_aligned) begin
              r_pc <= bus.redirect_pc;
            end else begin
              r_fault    <= 1'b1;
              r_fault_pc <= bus.redirect_pc;
              r_state    <= ST_FAULT;
            end
          end else if (w_push) begin
            r_pc <= r_pc + XLEN'(4);
          end
        end
        ST_FAULT: begin
          if (bus.redirect_valid) begin
            if (w_aligned) begin
              r_fault <= 1'b0;
              r_pc    <= bus.redirect_pc;
              r_state <= ST_FETCH;
            end else begin
              r_fault_pc <= bus.redirect_pc;
            end
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign bus.mem_addr  = r_pc;
  assign bus.out_valid = !w_empty;
  assign bus.out_pc    = w_head.pc;
  assign bus.out_instr = w_head.instr;
  assign bus.fault     = r_fault;
  assign bus.fault_pc  = r_fault_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench: queue-based reference model of the fetch buffer plus directed scenarios.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam int          DEPTH = 2;

  logic clk;
  logic rst;
  instr_fetch_if bus();

  instr_fetch #(
    .RESET_PC   (RPC),
    .BYTE_SWAP  (1'b1),
    .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory: mem[i] = A0B0C0D0 + i.
  always_comb bus.mem_rdata = 32'hA0B0C0D0 + (bus.mem_addr >> 2);

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_instr(input logic [31:0] addr);
    logic [31:0] w;
    logic [31:0] r;
    w = 32'hA0B0C0D0 + addr / 4;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
    return r;
  endfunction

  // Reference model: buffer contents as a queue of {pc, instr}, fetch pointer, fault status.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc  = RPC;
  bit          m_fault = 1'b0;
  logic [31:0] m_fpc = 32'h0;

  always @(posedge clk) begin : model
    bit pop;
    bit room;
    if (rst) begin
      exp_q.delete();
      m_pc    = RPC;
      m_fault = 1'b0;
      m_fpc   = 32'h0;
    end else if (m_fault) begin
      if (bus.redirect_valid) begin
        if (bus.redirect_pc % 4 == 0) begin
          m_fault = 1'b0;
          m_pc    = bus.redirect_pc;
        end else begin
          m_fpc = bus.redirect_pc;
        end
      end
    end else if (bus.redirect_valid) begin
      exp_q.delete();
      if (bus.redirect_pc % 4 == 0) m_pc = bus.redirect_pc;
      else begin
        m_fault = 1'b1;
        m_fpc   = bus.redirect_pc;
      end
    end else begin
      pop  = (exp_q.size() > 0) && bus.out_ready;
      room = (exp_q.size() < DEPTH) || pop;
      if (pop) void'(exp_q.pop_front());
      if (room) begin
        exp_q.push_back({m_pc, ref_instr(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // Monitor: compare DUT outputs with the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_q.size() != 0});
      check("mem_addr", bus.mem_addr, m_pc);
      check("fault", {31'b0, bus.fault}, {31'b0, m_fault});
      check("fault_pc", bus.fault_pc, m_fpc);
      if (exp_q.size() != 0 && bus.out_valid) begin
        check("out_pc", bus.out_pc, exp_q[0][63:32]);
        check("out_instr", bus.out_instr, exp_q[0][31:0]);
      end
    end
  end

  task automatic cyc(input bit r, input bit rv, input logic [31:0] rp, input bit rdy);
    rst                = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.out_ready      = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] a;
    int unsigned k;
    bit          rdy;

    // Reset
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk_en = 1'b1;
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, RPC);
    check("rst_fault", {31'b0, bus.fault}, 32'h0);

    // T1: streaming from reset
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1_valid", {31'b0, bus.out_valid}, 32'h1);
    check("t1_pc0", bus.out_pc, 32'h0);
    check("t1_instr0", bus.out_instr, 32'hD0C0B0A0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1_pc1", bus.out_pc, 32'h4);
    check("t1_instr1", bus.out_instr, 32'hD1C0B0A0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1_pc2", bus.out_pc, 32'h8);

    // T2: backpressure fills the buffer
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    check("t2_mem_addr_frozen", bus.mem_addr, 32'h8);
    check("t2_head_pc", bus.out_pc, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("t2_rel_pc4", bus.out_pc, 32'h4);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("t2_rel_pc8", bus.out_pc, 32'h8);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("t2_rel_pc12", bus.out_pc, 32'hC);

    // T3: redirect coincident with a pop
    cyc(1'b0, 1'b1, 32'h40, 1'b1);
    check("t3_flush_valid", {31'b0, bus.out_valid}, 32'h0);
    check("t3_mem_addr", bus.mem_addr, 32'h40);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("t3_pc", bus.out_pc, 32'h40);

    // T4: misaligned redirect, fault, recovery
    cyc(1'b0, 1'b1, 32'h42, 1'b1);
    check("t4_fault", {31'b0, bus.fault}, 32'h1);
    check("t4_fault_pc", bus.fault_pc, 32'h42);
    check("t4_valid", {31'b0, bus.out_valid}, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_hold_valid", {31'b0, bus.out_valid}, 32'h0);
    cyc(1'b0, 1'b1, 32'h43, 1'b1);
    check("t4_fault_pc2", bus.fault_pc, 32'h43);
    cyc(1'b0, 1'b1, 32'h80, 1'b1);
    check("t4_exit_fault", {31'b0, bus.fault}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_pc", bus.out_pc, 32'h80);

    // T5: PC wrap-around
    cyc(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("t5_pc_f8", bus.out_pc, 32'hFFFF_FFF8);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("t5_pc_fc", bus.out_pc, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("t5_pc_wrap", bus.out_pc, 32'h0);

    // Random traffic: backpressure, redirects (some misaligned), occasional reset
    for (int i = 0; i < 400; i++) begin
      k   = $urandom_range(99);
      rdy = ($urandom_range(9) < 7);
      a   = $urandom();
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      if (k < 5)       cyc(1'b0, 1'b1, a, rdy);
      else if (k < 7)  cyc(1'b1, 1'b0, 32'h0, rdy);
      else             cyc(1'b0, 1'b0, a, rdy);
    end

    // T6: reset with a full buffer
    cyc(1'b0, 1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    check("t6_full_valid", {31'b0, bus.out_valid}, 32'h1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    check("t6_rst_valid", {31'b0, bus.out_valid}, 32'h0);
    check("t6_rst_fault", {31'b0, bus.fault}, 32'h0);
    check("t6_rst_addr", bus.mem_addr, RPC);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("t6_valid", {31'b0, bus.out_valid}, 32'h1);
    check("t6_pc", bus.out_pc, RPC);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
